// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory, keeps one request
// in flight, and fills the IF/ID pipeline register. It supports stall and branch redirect.
module fetch_stage #(
  parameter int                     WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] if_id_pc,
  output logic [WORD_LEN-1:0] if_id_instr,
  output logic                if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

  state_t              r_state;
  logic [WORD_LEN-1:0] r_pc;
  logic [WORD_LEN-1:0] r_target;
  logic [WORD_LEN-1:0] r_hold_instr;
  logic [WORD_LEN-1:0] r_if_id_pc;
  logic [WORD_LEN-1:0] r_if_id_instr;
  logic                r_if_id_valid;

  logic                w_done;
  logic                w_eb;
  logic [WORD_LEN-1:0] w_pc_next;

  // The request drops combinationally with rst so a late ready during reset is never taken
  // as a completion.
  assign imem_req  = ~rst & (r_state != HOLD);
  assign imem_addr = r_pc;
  assign w_done    = imem_req & imem_ready;
  assign w_eb      = branch_taken & r_if_id_valid & ~freeze;
  assign w_pc_next = r_pc + PC_STEP;

  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;

  // NOTE: state uses non-blocking assignments only, so every branch below sees the values
  // the registers held at the start of the cycle. Evaluation order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_target      <= '0;
      r_hold_instr  <= '0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (w_eb) begin
            r_if_id_valid <= 1'b0;
            if (w_done) begin
              r_pc <= branch_target;
            end else begin
              r_target <= branch_target;
              r_state  <= DRAIN;
            end
          end else if (freeze) begin
            // The word arriving under a stall is parked; the PC keeps pointing at it.
            if (w_done) begin
              r_hold_instr <= imem_rdata;
              r_state      <= HOLD;
            end
          end else if (w_done) begin
            r_if_id_pc    <= w_pc_next;
            r_if_id_instr <= imem_rdata;
            r_if_id_valid <= 1'b1;
            r_pc          <= w_pc_next;
          end else begin
            r_if_id_valid <= 1'b0;
          end
        end

        DRAIN: begin
          r_if_id_valid <= 1'b0;
          if (w_done) begin
            r_pc    <= r_target;
            r_state <= FETCH;
          end
        end

        HOLD: begin
          if (w_eb) begin
            r_if_id_valid <= 1'b0;
            r_pc          <= branch_target;
            r_state       <= FETCH;
          end else if (!freeze) begin
            r_if_id_pc    <= w_pc_next;
            r_if_id_instr <= r_hold_instr;
            r_if_id_valid <= 1'b1;
            r_pc          <= w_pc_next;
            r_state       <= FETCH;
          end
        end

        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WORD_LEN, default 32, datapath/address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  hazard stall from ID; IF/ID register and PC hold.
REQ-006 branch_taken  input  1  branch condition from ID condition check, for the instruction in IF/ID.
REQ-007 branch_target  input  WORD_LEN  redirect address, valid when branch_taken=1.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  WORD_LEN  fetch address, equals PC register.
REQ-010 imem_ready  input  1  memory completes request this cycle (variable latency, >=0 wait cycles).
REQ-011 imem_rdata  input  WORD_LEN  instruction word, valid when imem_req=1 and imem_ready=1.
REQ-012 if_id_pc  output  WORD_LEN  PC+4 of the instruction in IF/ID.
REQ-013 if_id_instr  output  WORD_LEN  instruction in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 States SHALL be FETCH, DRAIN, HOLD; imem_req=1 in FETCH and DRAIN, 0 in HOLD and whenever rst=1.
REQ-016 imem_addr and PC SHALL remain stable while imem_req=1 until the cycle imem_ready=1 (no request cancellation).
REQ-017 Completion = imem_req & imem_ready; zero-wait completion in the same cycle as request SHALL be supported.
REQ-018 Effective branch eb = branch_taken & if_id_valid & ~freeze; branch_taken with if_id_valid=0 or freeze=1 SHALL be ignored.
REQ-019 Priority each cycle: rst > eb > freeze > normal.
REQ-020 FETCH, completion, eb=0, freeze=0: IF/ID <= {PC+4, imem_rdata}, valid<=1, PC<=PC+4, stay FETCH (one instruction per cycle with zero-wait memory).
REQ-021 FETCH, completion, freeze=1: IF/ID holds, response captured in hold buffer, PC unchanged, go HOLD.
REQ-022 FETCH, no completion, eb=0: freeze=0 -> if_id_valid<=0 (bubble); freeze=1 -> IF/ID holds.
REQ-023 FETCH, eb=1, completion: response discarded, if_id_valid<=0, PC<=branch_target, stay FETCH.
REQ-024 FETCH, eb=1, no completion: target latched, if_id_valid<=0, go DRAIN.
REQ-025 DRAIN: on completion response discarded, PC<=latched target, go FETCH; if_id_valid stays 0 throughout.
REQ-026 HOLD, freeze=1: everything holds.
REQ-027 HOLD, freeze=0, eb=0: IF/ID <= {PC+4, buffered instr}, valid<=1, PC<=PC+4, go FETCH.
REQ-028 HOLD, eb=1: buffer discarded, if_id_valid<=0, PC<=branch_target, go FETCH.
REQ-029 PC+4 SHALL wrap modulo 2^WORD_LEN (0xFFFFFFFC -> 0x00000000); no alignment check on branch_target.
REQ-030 At most one outstanding request; hold buffer depth exactly one.

Reset
REQ-031 On rising clk with rst=1: PC<=RESET_PC, state<=FETCH, if_id_valid<=0, if_id_pc<=0, if_id_instr<=0, hold buffer and latched target cleared.
REQ-032 Reset mid-request or in DRAIN/HOLD SHALL abandon the transaction; a late imem_ready after reset is treated as completion of the new RESET_PC request only if imem_req=1 that cycle.
REQ-033 First request SHALL issue the cycle after rst deasserts, imem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory, no freeze/branch, rdata=addr^0xA5A5A5A5 -> addresses 0,4,8,12 consecutive cycles; if_id_pc 4,8,12,16 with valid=1 one cycle later.
REQ-035 Memory with 2 wait cycles -> imem_addr held 3 cycles per fetch; if_id_valid=0 for 2 of every 3 cycles.
REQ-036 freeze=1 for 3 cycles while completion at PC=8 -> HOLD, IF/ID unchanged; after release if_id_pc=12, instr=word@8, next fetch at 12, no word lost or duplicated.
REQ-037 branch_taken=1, target=0x100, if_id_valid=1, with 3-wait request pending at PC=0x20 -> imem_addr stays 0x20 until ready, response discarded, next fetch 0x100, no valid IF/ID for 0x20.
REQ-038 branch_taken=1 with freeze=1 -> ignored, PC unchanged; branch_taken=1 with if_id_valid=0 -> ignored.
REQ-039 PC=0xFFFFFFFC fetch -> if_id_pc=0, next imem_addr=0; rst asserted in HOLD -> next cycle imem_addr=RESET_PC, if_id_valid=0.
